serial_chunk_add: RTL and testbench
===================================

SERIAL_CHUNK_ADD -- requirements
Module: serial_chunk_add

Interface
REQ-001 Parameter N, default 32: operand/result width in bits.
REQ-002 Parameter W, default 8: chunk width added per cycle; K = N/W chunks.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  operand set a/b/ci presented.
REQ-006 in_ready  output  1  block can accept an operand set.
REQ-007 a  input  N  operand A.
REQ-008 b  input  N  operand B.
REQ-009 ci  input  1  carry in.
REQ-010 out_valid  output  1  result c/co valid.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 c  output  N  registered sum, a+b+ci mod 2^N.
REQ-013 co  output  1  registered carry out of bit N-1.

Function
REQ-014 The block SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-015 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-016 IDLE: on in_valid&&in_ready, the block SHALL capture a, b, ci into internal registers, clear chunk index to 0, and go to RUN.
REQ-017 RUN: each cycle the block SHALL add chunk idx of the captured a, b, plus the running carry, write the W-bit sum into c[idx*W +: W], update the running carry, and increment idx.
REQ-018 RUN: when idx==K-1 is processed, the block SHALL load co with the final carry and go to DONE.
REQ-019 Latency SHALL be exactly K cycles from the accepting edge to first cycle of out_valid=1 (N=32,W=8 -> 4).
REQ-020 DONE: c, co SHALL hold stable while out_valid=1 and out_ready=0.
REQ-021 DONE with out_ready=1: the block SHALL go to IDLE on that edge; a new operand SHALL NOT be accepted in the same cycle (in_ready=0 in DONE).
REQ-022 Input changes on a, b, ci outside the accepting cycle SHALL NOT affect the result in progress.
REQ-023 The index counter SHALL be max(1,$clog2(K)) bits and SHALL NOT wrap within one operation.
REQ-024 K==1 (W==N) SHALL be supported: one RUN cycle, latency 1.
REQ-025 N%W!=0 or W<1 SHALL be rejected at elaboration with a fatal message.

Reset
REQ-026 While rst_n=0 the block SHALL force state=IDLE, idx=0, running carry=0, c=0, co=0, out_valid=0, in_ready=0.
REQ-027 In-ready SHALL rise in the first cycle after rst_n deasserts.
REQ-028 Reset asserted in RUN or DONE SHALL abandon the operation with no out_valid pulse.

Configuration
REQ-029 Macro SERIAL_CHUNK_ADD_OVERFLOW_EN: when defined, an output ov (1 bit) SHALL exist, registered with co, equal to (a[N-1]==b[N-1]) && (c[N-1]!=a[N-1]) for the captured operands, reset 0, held in DONE.
REQ-030 When undefined, the ov port and its logic SHALL be absent; all other behaviour identical.

Structure
REQ-031 The FSM state enum typedef (IDLE, RUN, DONE) SHALL reside in the shared fixed_point_arithmetic_pkg.
REQ-032 The per-chunk adder SHALL be a combinational sub-module chunk_add (W-bit a, b, ci -> W-bit sum, carry out), instantiated once.

Verification
REQ-033 N=32,W=8: a=0x0000_0001, b=0x0000_0001, ci=0 -> after 4 cycles out_valid=1, c=0x0000_0002, co=0.
REQ-034 a=0xFFFF_FFFF, b=0x0000_0000, ci=1 -> c=0x0000_0000, co=1 (carry ripples through all 4 chunks).
REQ-035 out_ready held 0 for 5 cycles in DONE while a/b/in_valid toggle -> c, co, out_valid unchanged, in_ready=0; out_ready=1 -> IDLE next cycle.
REQ-036 rst_n pulsed low during RUN cycle 2 -> c=0, co=0, out_valid never asserted; next accepted 0x10+0x20 yields 0x30.
REQ-037 With SERIAL_CHUNK_ADD_OVERFLOW_EN: a=0x7FFF_FFFF, b=0x0000_0001, ci=0 -> c=0x8000_0000, co=0, ov=1.
REQ-038 Random back-to-back operands with random out_ready stalls, W in {1,8,32} -> every c/co matches a+b+ci reference, no lost or duplicated results.

Source files
------------

// File: rtl/fixed_point_arithmetic_pkg.sv
// Shared types for the fixed-point arithmetic blocks: FSM state encoding and sizing helpers.
package fixed_point_arithmetic_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Counter width that never collapses to zero bits when only one chunk exists.
   function automatic int idx_width(input int k);
      return (k > 1) ? $clog2(k) : 1;
   endfunction

endpackage

// File: rtl/serial_chunk_add_chunk.sv
// Combinational W-bit adder slice with carry in/out, reused once per cycle by serial_chunk_add.
module chunk_add #(
   parameter int W = 8
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         ci,
   output logic [W-1:0] sum,
   output logic         co
);

   logic [W:0] total_s;

   // One extra bit captures the carry out of the slice.
   always_comb begin
      total_s = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
   end

   assign sum = total_s[W-1:0];
   assign co  = total_s[W];

endmodule

// File: rtl/serial_chunk_add.sv
// Serial N-bit adder processing one W-bit chunk per cycle (IDLE -> RUN x K -> DONE).
// Optional signed-overflow output ov enabled by defining SERIAL_CHUNK_ADD_OVERFLOW_EN.
module serial_chunk_add
   import fixed_point_arithmetic_pkg::*;
#(
   parameter int N = 32,
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         ci,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] c,
   output logic         co
`ifdef SERIAL_CHUNK_ADD_OVERFLOW_EN
   ,
   output logic         ov
`endif
);

   localparam int K     = (W < 1) ? 1 : N / W;
   localparam int IDX_W = idx_width(K);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(K - 1);

   if (W < 1) begin : g_bad_w
      $fatal(1, "serial_chunk_add: W must be at least 1");
   end else if ((N % W) != 0) begin : g_bad_nw
      $fatal(1, "serial_chunk_add: N must be a multiple of W");
   end

   state_e             state_r;
   state_e             state_nx_s;
   logic               in_ready_r;
   logic               out_valid_r;
   logic [N-1:0]       a_r;
   logic [N-1:0]       b_r;
   logic [IDX_W-1:0]   idx_r;
   logic               carry_r;
   logic [N-1:0]       c_r;
   logic               co_r;
   logic [W-1:0]       a_chunk_s;
   logic [W-1:0]       b_chunk_s;
   logic [W-1:0]       sum_s;
   logic               carry_s;
   logic               accept_s;
   logic               last_s;

   // Operand chunk selection for the current index.
   always_comb begin
      a_chunk_s = a_r[int'(idx_r) * W +: W];
      b_chunk_s = b_r[int'(idx_r) * W +: W];
      accept_s  = in_valid && in_ready_r;
      last_s    = (idx_r == LAST_IDX);
   end

   chunk_add #(
      .W (W)
   ) u_chunk_add (
      .a   (a_chunk_s),
      .b   (b_chunk_s),
      .ci  (carry_r),
      .sum (sum_s),
      .co  (carry_s)
   );

   // Next-state decode.
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               state_nx_s = RUN;
            end else begin
               state_nx_s = IDLE;
            end
         end
         RUN: begin
            if (last_s) begin
               state_nx_s = DONE;
            end else begin
               state_nx_s = RUN;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_nx_s = IDLE;
            end else begin
               state_nx_s = DONE;
            end
         end
         default: begin
            state_nx_s = IDLE;
         end
      endcase
   end

   // State register plus registered handshake flags derived from the next state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         in_ready_r  <= 1'b0;
         out_valid_r <= 1'b0;
      end else begin
         state_r     <= state_nx_s;
         in_ready_r  <= (state_nx_s == IDLE);
         out_valid_r <= (state_nx_s == DONE);
      end
   end

   // Operand capture and chunk-by-chunk accumulation of the sum.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_r     <= '0;
         b_r     <= '0;
         idx_r   <= '0;
         carry_r <= 1'b0;
         c_r     <= '0;
         co_r    <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (accept_s) begin
                  a_r     <= a;
                  b_r     <= b;
                  carry_r <= ci;
                  idx_r   <= '0;
               end
            end
            RUN: begin
               c_r[int'(idx_r) * W +: W] <= sum_s;
               carry_r                   <= carry_s;
               // Index holds on the last chunk rather than wrapping.
               if (last_s) begin
                  co_r <= carry_s;
               end else begin
                  idx_r <= idx_r + IDX_W'(1);
               end
            end
            DONE: begin
               co_r <= co_r;
            end
            default: begin
               idx_r <= '0;
            end
         endcase
      end
   end

`ifdef SERIAL_CHUNK_ADD_OVERFLOW_EN
   logic ov_r;

   // Signed overflow: like-signed operands whose sum flips sign; top bit comes from the last chunk.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ov_r <= 1'b0;
      end else if ((state_r == RUN) && last_s) begin
         ov_r <= (a_r[N-1] == b_r[N-1]) && (sum_s[W-1] != a_r[N-1]);
      end else begin
         ov_r <= ov_r;
      end
   end

   assign ov = ov_r;
`endif

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign c         = c_r;
   assign co        = co_r;

endmodule

// File: tb/tb_serial_chunk_add.sv
// Directed bench for serial_chunk_add: three instances (W = 8, 1, 32) share stimulus.
module tb_serial_chunk_add;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic        ci = 1'b0;
   logic [31:0] a = 32'd0;
   logic [31:0] b = 32'd0;

   logic [31:0] c8, c1, c32;
   logic        co8, co1, co32;
   logic        vld8, vld1, vld32;
   logic        rdy8, rdy1, rdy32;
`ifdef SERIAL_CHUNK_ADD_OVERFLOW_EN
   logic        ov8, ov1, ov32;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   serial_chunk_add #(.N(32), .W(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy8),
      .a(a), .b(b), .ci(ci), .out_valid(vld8), .out_ready(out_ready),
      .c(c8), .co(co8)
`ifdef SERIAL_CHUNK_ADD_OVERFLOW_EN
      , .ov(ov8)
`endif
   );

   serial_chunk_add #(.N(32), .W(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1),
      .a(a), .b(b), .ci(ci), .out_valid(vld1), .out_ready(out_ready),
      .c(c1), .co(co1)
`ifdef SERIAL_CHUNK_ADD_OVERFLOW_EN
      , .ov(ov1)
`endif
   );

   serial_chunk_add #(.N(32), .W(32)) dut32 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy32),
      .a(a), .b(b), .ci(ci), .out_valid(vld32), .out_ready(out_ready),
      .c(c32), .co(co32)
`ifdef SERIAL_CHUNK_ADD_OVERFLOW_EN
      , .ov(ov32)
`endif
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One full operation: accept, scramble inputs while running, stall, then release.
   task automatic do_op(input logic [31:0] av, input logic [31:0] bv, input logic civ,
                        input logic [31:0] exp_c, input logic exp_co, input int stall,
                        input string tag);
      int cyc;
      int lat8;
      int lat1;
      int lat32;
      cyc = 0;
      while (!(rdy8 && rdy1 && rdy32) && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      check({tag, "_ready"}, {61'd0, rdy8, rdy1, rdy32}, 64'd7);
      a = av;
      b = bv;
      ci = civ;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      cyc = 0;
      lat8 = 0;
      lat1 = 0;
      lat32 = 0;
      while (!(vld8 && vld1 && vld32) && cyc < 64) begin
         a = $urandom;
         b = $urandom;
         ci = 1'($urandom_range(0, 1));
         @(negedge clk);
         cyc++;
         if (vld8 && lat8 == 0) lat8 = cyc;
         if (vld1 && lat1 == 0) lat1 = cyc;
         if (vld32 && lat32 == 0) lat32 = cyc;
      end
      check({tag, "_lat8"}, 64'(lat8), 64'd4);
      check({tag, "_lat1"}, 64'(lat1), 64'd32);
      check({tag, "_lat32"}, 64'(lat32), 64'd1);
      check({tag, "_c8"}, {32'd0, c8}, {32'd0, exp_c});
      check({tag, "_co8"}, {63'd0, co8}, {63'd0, exp_co});
      check({tag, "_c1"}, {31'd0, co1, c1}, {31'd0, exp_co, exp_c});
      check({tag, "_c32"}, {31'd0, co32, c32}, {31'd0, exp_co, exp_c});
`ifdef SERIAL_CHUNK_ADD_OVERFLOW_EN
      check({tag, "_ov"}, {61'd0, ov8, ov1, ov32},
            ((av[31] == bv[31]) && (exp_c[31] != av[31])) ? 64'd7 : 64'd0);
`endif
      for (int s = 0; s < stall; s++) begin
         a = $urandom;
         b = $urandom;
         in_valid = ~in_valid;
         @(negedge clk);
         check({tag, "_hold_c"}, {31'd0, co8, c8}, {31'd0, exp_co, exp_c});
         check({tag, "_hold_flags"}, {60'd0, vld8, rdy8, vld1, rdy32}, 64'b1010);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, "_release"}, {58'd0, vld8, vld1, vld32, rdy8, rdy1, rdy32}, 64'b000111);
   endtask

   initial begin
      logic [32:0] sum;
      logic [31:0] ra;
      logic [31:0] rb;
      logic        rc;
      logic        seen;

      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_in_ready", {61'd0, rdy8, rdy1, rdy32}, 64'd0);
      check("rst_out_valid", {61'd0, vld8, vld1, vld32}, 64'd0);
      check("rst_c_co", {31'd0, co8, c8}, 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("in_ready_after_rst", {61'd0, rdy8, rdy1, rdy32}, 64'd7);

      do_op(32'h0000_0001, 32'h0000_0001, 1'b0, 32'h0000_0002, 1'b0, 0, "one_plus_one");
      do_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 0, "full_ripple");
      do_op(32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 5, "stall5");
      do_op(32'h8000_0000, 32'h8000_0000, 1'b1, 32'h0000_0001, 1'b1, 2, "top_carry");
`ifdef SERIAL_CHUNK_ADD_OVERFLOW_EN
      do_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 0, "overflow");
`endif

      // Abandon an operation part-way through RUN.
      a = 32'h0F0F_0F0F;
      b = 32'h0101_0101;
      ci = 1'b0;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort_c_co", {31'd0, co8, c8}, 64'd0);
      check("abort_flags", {60'd0, vld8, rdy8, vld1, vld32}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (vld8 || vld1 || vld32) seen = 1'b1;
      end
      check("abort_no_valid", {63'd0, seen}, 64'd0);
      do_op(32'h0000_0010, 32'h0000_0020, 1'b0, 32'h0000_0030, 1'b0, 1, "after_abort");

      for (int i = 0; i < 12; i++) begin
         ra = $urandom;
         rb = $urandom;
         rc = 1'($urandom_range(0, 1));
         sum = {1'b0, ra} + {1'b0, rb} + {32'd0, rc};
         do_op(ra, rb, rc, sum[31:0], sum[32], $urandom_range(0, 3), $sformatf("rand%0d", i));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule
